// File: rtl/otg_bus_responder.sv
// OTG parallel-bus responder: command/data register file plus RX (bus->local) and TX (local->bus) word FIFOs.
// Define OTG_RESP_IRQ_EN to build INT_STAT/INT_EN and the interrupt outputs; otherwise they are absent.
module otg_bus_responder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        otg_rst_n,
    input  logic [1:0]  otg_addr,
    input  logic        otg_cs_n,
    input  logic        otg_rd_n,
    input  logic        otg_wr_n,
    input  logic [15:0] otg_data_in,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    output logic        otg_int0,
    output logic        otg_int1,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready
);
    // state   | meaning
    // S_IDLE  | no access in progress, waiting for a strobe fall with CS low
    // S_READ  | driving read data until synced RD_N rises
    // S_WRITE | sampling write data until synced WR_N rises, then commit
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic unused_addr1;
    assign unused_addr1 = otg_addr[1];

    logic [1:0] rstn_sync_q;
    logic       rst;

    always_ff @(posedge clk) begin
        if (reset) rstn_sync_q <= 2'b11;
        else       rstn_sync_q <= {rstn_sync_q[0], otg_rst_n};
    end
    assign rst = reset | ~rstn_sync_q[1];

    // Strobe syncs reset low so a strobe only counts as high once really sampled high.
    logic [1:0]  cs_sync_q, rd_sync_q, wr_sync_q, a0_sync_q;
    logic        rd_prev_q, wr_prev_q, armed_q;
    logic [15:0] d_meta_q, d_sync_q;
    logic        cs_s, rd_s, wr_s, a0_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q <= 2'b11;
            rd_sync_q <= 2'b00;
            wr_sync_q <= 2'b00;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            cs_sync_q <= {cs_sync_q[0], otg_cs_n};
            rd_sync_q <= {rd_sync_q[0], otg_rd_n};
            wr_sync_q <= {wr_sync_q[0], otg_wr_n};
            rd_prev_q <= rd_sync_q[1];
            wr_prev_q <= wr_sync_q[1];
            if (rd_sync_q[1] && wr_sync_q[1]) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        a0_sync_q <= {a0_sync_q[0], otg_addr[0]};
        d_meta_q  <= otg_data_in;
        d_sync_q  <= d_meta_q;
    end

    assign cs_s = cs_sync_q[1];
    assign rd_s = rd_sync_q[1];
    assign wr_s = wr_sync_q[1];
    assign a0_s = a0_sync_q[1];

    logic start_rd, start_wr, rd_rise, wr_rise;
    assign start_rd = armed_q & ~cs_s & rd_prev_q & ~rd_s;
    assign start_wr = armed_q & ~cs_s & wr_prev_q & ~wr_s;
    assign rd_rise  = ~rd_prev_q & rd_s;
    assign wr_rise  = ~wr_prev_q & wr_s;

    state_t      state_q;
    logic        addr0_q, buf_rd_q, tx_was_empty_q;
    logic [15:0] wdata_q, scratch_q, dout_q, rd_val_d;
    logic [3:0]  idx_q, stat_q, en_q;
    logic        oe_q;

    logic [15:0]   rx_mem [FIFO_DEPTH];
    logic [15:0]   tx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q, tx_wr_ptr_q, tx_rd_ptr_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic          rx_full, tx_empty, tx_full;
    logic          wr_commit, data_wr, bus_buf_rd, rx_push, rx_push_ok, rx_pop_ok;
    logic          tx_push_ok, tx_pop_ok;

    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);

    assign wr_commit  = (state_q == S_WRITE) & wr_rise;
    assign data_wr    = wr_commit & ~addr0_q;
    assign bus_buf_rd = (state_q == S_READ) & rd_rise & buf_rd_q;
    assign rx_push    = data_wr & (idx_q == 4'd4);
    assign rx_push_ok = rx_push & ~rx_full;
    assign rx_pop_ok  = rx_valid & rx_ready;
    assign tx_push_ok = tx_valid & ~tx_full;
    assign tx_pop_ok  = bus_buf_rd & ~tx_was_empty_q;

    always_comb begin
        rd_val_d = '0;
        if (a0_s) begin
            rd_val_d = {12'h000, idx_q};
        end else begin
            case (idx_q)
                4'd0:    rd_val_d = {12'h000, stat_q};
                4'd1:    rd_val_d = {12'h000, en_q};
                4'd2:    rd_val_d = 16'(rx_cnt_q);
                4'd3:    rd_val_d = 16'(tx_cnt_q);
                4'd4:    rd_val_d = tx_empty ? 16'h0000 : tx_mem[tx_rd_ptr_q];
                4'd5:    rd_val_d = scratch_q;
                default: rd_val_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr0_q        <= 1'b0;
            buf_rd_q       <= 1'b0;
            tx_was_empty_q <= 1'b0;
            wdata_q        <= '0;
            scratch_q      <= '0;
            idx_q          <= '0;
            dout_q         <= '0;
            oe_q           <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_rd) begin
                        state_q        <= S_READ;
                        addr0_q        <= a0_s;
                        buf_rd_q       <= ~a0_s & (idx_q == 4'd4);
                        tx_was_empty_q <= tx_empty;
                        dout_q         <= rd_val_d;
                        oe_q           <= 1'b1;
                    end else if (start_wr) begin
                        state_q <= S_WRITE;
                        addr0_q <= a0_s;
                        wdata_q <= d_sync_q;
                    end
                end
                S_READ: begin
                    if (rd_rise) begin
                        state_q <= S_IDLE;
                        oe_q    <= 1'b0;
                        dout_q  <= '0;
                    end
                end
                S_WRITE: begin
                    if (wr_rise) begin
                        state_q <= S_IDLE;
                        if (addr0_q)                idx_q     <= wdata_q[3:0];
                        else if (idx_q == 4'd5)     scratch_q <= wdata_q;
                    end else begin
                        wdata_q <= d_sync_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign otg_data_out = dout_q;
    assign otg_data_oe  = oe_q;

    assign rx_cnt_d = rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop_ok);
    assign tx_cnt_d = tx_cnt_q + CW'(tx_push_ok) - CW'(tx_pop_ok);

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wr_ptr_q] <= wdata_q;
        if (tx_push_ok) tx_mem[tx_wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
        end else begin
            if (rx_push_ok) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
            if (rx_pop_ok)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
            if (tx_push_ok) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
            if (tx_pop_ok)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    assign rx_data  = rx_mem[rx_rd_ptr_q];
    assign rx_valid = (rx_cnt_q != '0);
    assign tx_ready = ~tx_full;

`ifdef OTG_RESP_IRQ_EN
    logic [3:0] stat_set, stat_clr, stat_d;

    // A set event wins over a W1C of the same bit in the same cycle.
    always_comb begin
        stat_set = {bus_buf_rd & tx_was_empty_q,
                    rx_push & rx_full,
                    (tx_cnt_q == '0) & (tx_cnt_d != '0),
                    (rx_cnt_d == FULL_CNT) & (rx_cnt_q != FULL_CNT)};
        stat_clr = (data_wr && idx_q == 4'd0) ? wdata_q[3:0] : 4'h0;
        stat_d   = (stat_q & ~stat_clr) | stat_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
            en_q   <= '0;
        end else begin
            stat_q <= stat_d;
            if (data_wr && idx_q == 4'd1) en_q <= wdata_q[3:0];
        end
    end

    assign otg_int0 = |(stat_q[1:0] & en_q[1:0]);
    assign otg_int1 = |(stat_q[3:2] & en_q[3:2]);
`else
    assign stat_q   = '0;
    assign en_q     = '0;
    assign otg_int0 = 1'b0;
    assign otg_int1 = 1'b0;
`endif

endmodule

// File: tb/tb_otg_bus_responder.sv
// Self-checking bench for otg_bus_responder: queue-based model plus directed bus/local traffic.
module tb_otg_bus_responder;
    localparam int DEPTH = 16;
`ifdef OTG_RESP_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, otg_rst_n, otg_cs_n, otg_rd_n, otg_wr_n;
    logic [1:0]  otg_addr;
    logic [15:0] otg_data_in, otg_data_out, rx_data, tx_data;
    logic        otg_data_oe, otg_int0, otg_int1, rx_valid, rx_ready, tx_valid, tx_ready;

    otg_bus_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .otg_rst_n(otg_rst_n), .otg_addr(otg_addr),
        .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
        .otg_data_in(otg_data_in), .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe),
        .otg_int0(otg_int0), .otg_int1(otg_int1),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [15:0] rxq[$];
    logic [15:0] txq[$];
    logic [3:0]  m_idx, m_stat, m_en;
    logic [15:0] m_scratch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        rxq.delete();
        txq.delete();
        m_idx = '0; m_stat = '0; m_en = '0; m_scratch = '0;
    endtask

    task automatic mdl_tx_push(input logic [15:0] w);
        if (txq.size() < DEPTH) begin
            if (IRQ && txq.size() == 0) m_stat |= 4'b0010;
            txq.push_back(w);
        end
    endtask

    task automatic mdl_write(input bit a0, input logic [15:0] d);
        if (a0) m_idx = d[3:0];
        else case (m_idx)
            4'd0: if (IRQ) m_stat &= ~d[3:0];
            4'd1: if (IRQ) m_en = d[3:0];
            4'd4: begin
                if (rxq.size() < DEPTH) begin
                    rxq.push_back(d);
                    if (IRQ && rxq.size() == DEPTH) m_stat |= 4'b0001;
                end else if (IRQ) m_stat |= 4'b0100;
            end
            4'd5: m_scratch = d;
            default: ;
        endcase
    endtask

    task automatic mdl_read(input bit a0, output logic [15:0] e);
        e = '0;
        if (a0) e = {12'h000, m_idx};
        else case (m_idx)
            4'd0: e = {12'h000, m_stat};
            4'd1: e = {12'h000, m_en};
            4'd2: e = 16'(rxq.size());
            4'd3: e = 16'(txq.size());
            4'd4: begin
                if (txq.size() == 0) begin
                    e = 16'h0000;
                    if (IRQ) m_stat |= 4'b1000;
                end else e = txq.pop_front();
            end
            4'd5: e = m_scratch;
            default: e = '0;
        endcase
    endtask

    task automatic bus_write(input bit a0, input logic [15:0] d,
                             input bit push_tx = 1'b0, input logic [15:0] pw = 16'h0);
        chk_en = 1'b0;
        @(negedge clk);
        otg_addr = {~a0, a0}; otg_data_in = d; otg_cs_n = 1'b0; otg_wr_n = 1'b0;
        repeat (5) @(negedge clk);
        otg_wr_n = 1'b1;
        repeat (2) @(negedge clk);
        // Lands the local push on the same edge as the write commit.
        if (push_tx) begin tx_data = pw; tx_valid = 1'b1; end
        @(negedge clk);
        tx_valid = 1'b0; otg_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        mdl_write(a0, d);
        if (push_tx) mdl_tx_push(pw);
        chk_en = 1'b1;
    endtask

    task automatic bus_read(input bit a0, input string name, output logic [15:0] v);
        logic [15:0] e;
        chk_en = 1'b0;
        @(negedge clk);
        otg_addr = {~a0, a0}; otg_cs_n = 1'b0; otg_rd_n = 1'b0;
        repeat (4) @(negedge clk);
        chk({name, "_oe_on"}, otg_data_oe, 1);
        v = otg_data_out;
        @(negedge clk);
        otg_rd_n = 1'b1;
        repeat (2) @(negedge clk);
        chk({name, "_oe_hold"}, otg_data_oe, 1);
        chk({name, "_data_hold"}, otg_data_out, v);
        @(negedge clk);
        chk({name, "_oe_drop"}, otg_data_oe, 0);
        otg_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        mdl_read(a0, e);
        chk(name, v, e);
        chk_en = 1'b1;
    endtask

    task automatic tx_push(input logic [15:0] w);
        chk_en = 1'b0;
        @(negedge clk);
        tx_data = w; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        mdl_tx_push(w);
        chk_en = 1'b1;
    endtask

    task automatic rx_pop(input logic [15:0] exp);
        chk_en = 1'b0;
        @(negedge clk);
        chk("rx_pop_valid", rx_valid, 1);
        chk("rx_pop_data", rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        void'(rxq.pop_front());
        chk_en = 1'b1;
    endtask

    // Per-cycle comparison of the local-side and interrupt outputs against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("m_rx_valid", rx_valid, rxq.size() != 0);
            if (rxq.size() != 0) chk("m_rx_data", rx_data, rxq[0]);
            chk("m_tx_ready", tx_ready, txq.size() < DEPTH);
            chk("m_int0", otg_int0, IRQ & (|(m_stat[1:0] & m_en[1:0])));
            chk("m_int1", otg_int1, IRQ & (|(m_stat[3:2] & m_en[3:2])));
            chk("m_oe_idle", otg_data_oe, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        reset = 1'b1; otg_rst_n = 1'b1; otg_cs_n = 1'b1; otg_rd_n = 1'b1; otg_wr_n = 1'b1;
        otg_addr = 2'b00; otg_data_in = '0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
        mdl_reset();
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dout", otg_data_out, 16'h0000);
        chk("rst_oe", otg_data_oe, 0);
        chk("rst_int0", otg_int0, 0);
        chk("rst_int1", otg_int1, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        bus_read(1'b1, "idx_rst", v);  chk("idx_rst_lit", v, 16'h0000);

        // Scratch round trip and command readback
        bus_write(1'b1, 16'h0005);
        bus_write(1'b0, 16'hBEEF);
        bus_write(1'b1, 16'h0005);
        bus_read(1'b0, "scratch", v);  chk("scratch_lit", v, 16'hBEEF);
        bus_read(1'b1, "cmd_rd", v);   chk("cmd_rd_lit", v, 16'h0005);
        bus_write(1'b1, 16'h0007);
        bus_write(1'b0, 16'h1111);
        bus_read(1'b0, "reg7", v);     chk("reg7_lit", v, 16'h0000);

        // Enable all interrupts, fill RX to the brim, then overflow it
        bus_write(1'b1, 16'h0001);
        bus_write(1'b0, 16'h000F);
        bus_read(1'b0, "en_rd", v);    chk("en_lit", v, IRQ ? 16'h000F : 16'h0000);
        bus_write(1'b1, 16'h0004);
        for (int i = 0; i < DEPTH; i++) bus_write(1'b0, 16'(i));
        bus_write(1'b1, 16'h0002);
        bus_read(1'b0, "rx_level", v); chk("rx_level_lit", v, 16'd16);
        bus_write(1'b1, 16'h0000);
        bus_read(1'b0, "stat_full", v); chk("stat_full_lit", v, IRQ ? 16'h0001 : 16'h0000);
        chk("int0_full_lit", otg_int0, IRQ);
        bus_write(1'b1, 16'h0004);
        bus_write(1'b0, 16'h00FF);
        bus_write(1'b1, 16'h0000);
        bus_read(1'b0, "stat_ovf", v); chk("stat_ovf_lit", v, IRQ ? 16'h0005 : 16'h0000);
        chk("int1_ovf_lit", otg_int1, IRQ);
        for (int i = 0; i < DEPTH; i++) rx_pop(16'(i));
        @(negedge clk);
        chk("rx_drained", rx_valid, 0);

        // TX path: two words, then underflow
        tx_push(16'h1234);
        tx_push(16'h5678);
        bus_write(1'b1, 16'h0004);
        bus_read(1'b0, "tx_rd0", v);   chk("tx_rd0_lit", v, 16'h1234);
        bus_read(1'b0, "tx_rd1", v);   chk("tx_rd1_lit", v, 16'h5678);
        bus_write(1'b1, 16'h0003);
        bus_read(1'b0, "tx_level0", v); chk("tx_level0_lit", v, 16'h0000);
        bus_write(1'b1, 16'h0004);
        bus_read(1'b0, "tx_udf", v);   chk("tx_udf_lit", v, 16'h0000);
        bus_write(1'b1, 16'h0000);
        bus_read(1'b0, "stat_all", v); chk("stat_all_lit", v, IRQ ? 16'h000F : 16'h0000);

        // W1C of all bits on the same edge as a TX empty->non-empty event
        bus_write(1'b0, 16'h000F, 1'b1, 16'h9ABC);
        bus_read(1'b0, "stat_w1c", v); chk("stat_w1c_lit", v, IRQ ? 16'h0002 : 16'h0000);
        bus_write(1'b1, 16'h0003);
        bus_read(1'b0, "tx_level1", v); chk("tx_level1_lit", v, 16'h0001);

        // Bus reset in the middle of a SCRATCH write
        bus_write(1'b1, 16'h0004);
        bus_write(1'b0, 16'h4321);
        bus_write(1'b1, 16'h0005);
        chk_en = 1'b0;
        @(negedge clk);
        otg_addr = 2'b00; otg_data_in = 16'hA5A5; otg_cs_n = 1'b0; otg_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        otg_rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("brst_dout", otg_data_out, 16'h0000);
        chk("brst_oe", otg_data_oe, 0);
        chk("brst_int0", otg_int0, 0);
        chk("brst_int1", otg_int1, 0);
        chk("brst_rx_valid", rx_valid, 0);
        chk("brst_tx_ready", tx_ready, 1);
        otg_wr_n = 1'b1; otg_cs_n = 1'b1;
        @(negedge clk);
        otg_rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mdl_reset();
        chk_en = 1'b1;
        bus_read(1'b1, "idx_brst", v); chk("idx_brst_lit", v, 16'h0000);
        bus_write(1'b1, 16'h0005);
        bus_read(1'b0, "scratch_brst", v); chk("scratch_brst_lit", v, 16'h0000);
        bus_write(1'b1, 16'h0003);
        bus_read(1'b0, "tx_level_brst", v); chk("tx_level_brst_lit", v, 16'h0000);

        // TX full boundary: 16 pushes, a 17th is refused
        for (int i = 0; i < DEPTH; i++) tx_push(16'h0100 + 16'(i));
        @(negedge clk);
        chk("tx_full_lit", tx_ready, 0);
        tx_push(16'hDEAD);
        bus_read(1'b0, "tx_level_full", v); chk("tx_level_full_lit", v, 16'd16);
        bus_write(1'b1, 16'h0004);
        bus_read(1'b0, "tx_head", v);  chk("tx_head_lit", v, 16'h0100);
        @(negedge clk);
        chk("tx_ready_after_pop", tx_ready, 1);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/otg_bus_responder.md
# otg_bus_responder

Chip-side responder for the 16-bit parallel OTG bus (ADDR, CS_N, RD_N, WR_N, DATA, INT0/INT1, RST_N) driven by the USB host-interface wrapper. It decodes command/data accesses into a small register file and two word FIFOs, one per direction, between the bus and local logic. Interrupt lines are raised on FIFO events. It serves as a synthesizable loopback/peripheral endpoint and as the bench partner for the bus master. All bus inputs are asynchronous to `clk` and are synchronized internally.

## Interface
- `FIFO_DEPTH`, 16: words per FIFO; power of two, 4..256.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `otg_rst_n` in 1: bus reset; after sync, low acts exactly as `reset`.
- `otg_addr` in 2: bit0 = 1 command port, 0 data port; bit1 ignored.
- `otg_cs_n`, `otg_rd_n`, `otg_wr_n` in 1 each: active-low strobes.
- `otg_data_in` in 16: bus write data.
- `otg_data_out` out 16: bus read data.
- `otg_data_oe` out 1: high while the responder drives the bus.
- `otg_int0`, `otg_int1` out 1 each: active-high interrupts.
- `rx_data` out 16, `rx_valid` out 1, `rx_ready` in 1: host-to-local FIFO pop port.
- `tx_data` in 16, `tx_valid` in 1, `tx_ready` out 1: local-to-host FIFO push port; `tx_ready` = not full.

## Operation
- Strobes, address and data pass through 2-flop synchronizers; edges are detected on the synchronized strobes.
- Access start: sync CS_N low and RD_N or WR_N falling. Latch addr bit0 and access type. Ignore strobe edges while CS_N is high.
- Command write (addr0=1): `idx` <= data[3:0]. Command read returns {12'h0, idx}.
- Data access (addr0=0) targets register `idx`:
  - 0 INT_STAT: W1C.
  - 1 INT_EN: R/W, bits[3:0].
  - 2 RX_LEVEL: RO.
  - 3 TX_LEVEL: RO.
  - 4 BUF: write pushes the RX FIFO; read pops the TX FIFO.
  - 5 SCRATCH: R/W.
  - 6..15: read 0, write ignored.
- INT_STAT set events:
  - bit0: RX count reaches FIFO_DEPTH.
  - bit1: TX goes empty -> non-empty.
  - bit2: BUF write while RX full; word dropped.
  - bit3: BUF read while TX empty; returns 16'h0000.
- `otg_int0` = |(STAT[1:0] & EN[1:0]); `otg_int1` = |(STAT[3:2] & EN[3:2]).
- A set event and a W1C of the same bit in the same cycle: the bit stays set.
- FIFOs: FIFO_DEPTH x 16, pointer wrap with a count of log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop keeps the count unchanged; pop-on-empty and push-on-full are no-ops.
- `idx` does not auto-increment.

## Timing
- Reset values: `otg_data_out` 0, `otg_data_oe` 0, ints 0, `rx_valid` 0, `tx_ready` 1, `idx` 0, STAT/EN/SCRATCH 0, FIFOs empty.
- Read: `otg_data_out` is valid and `otg_data_oe`=1 by the 4th `clk` edge after RD_N falls. Data is held until sync RD_N rises; `otg_data_oe` drops 3 edges after RD_N rises.
- The BUF read pop commits on sync RD_N rise. The value read is the head word captured at access start.
- Write: data is sampled every cycle while sync WR_N is low. The last sample commits on the sync WR_N rising-edge cycle; register or FIFO updates are visible the next cycle.
- Bus master requirement: strobe low >= 4 clk, high gap >= 3 clk, ADDR/DATA stable while the strobe is low.
- The `rx_data` head is registered (show-ahead); pop on `rx_valid & rx_ready`. `tx_ready` updates the cycle after a push.
- Reset or `otg_rst_n` low mid-access aborts the access with no commit. After release, strobes must be observed high before a new access starts.

## Configuration
- `OTG_RESP_IRQ_EN` defined: INT_STAT/INT_EN and both interrupt outputs are implemented as described.
- `OTG_RESP_IRQ_EN` undefined:
  - `otg_int0`/`otg_int1` are tied 0.
  - Registers 0 and 1 read 0 and ignore writes.
  - FIFO overflow/underflow behaviour (drop / return 0) is unchanged.

## Test plan
- Command write 5, data write 16'hBEEF, command write 5, data read -> 16'hBEEF with `otg_data_oe` high during RD_N low; command read -> 16'h0005.
- idx=4, write 16 words 0..15 -> RX_LEVEL=16, STAT bit0=1, `otg_int0`=1 with EN=1. 17th write -> STAT bit2=1, word dropped. Drain `rx_*` -> 0..15 in order.
- Local push 16'h1234 and 16'h5678, idx=4, two bus reads -> 16'h1234 then 16'h5678, TX_LEVEL 0. Third read -> 16'h0000 and STAT bit3 set.
- Write STAT=16'h000F during the same cycle a TX empty->non-empty event fires -> bit1 stays 1, others clear.
- Assert `otg_rst_n` low mid-write to SCRATCH -> SCRATCH stays 0, all outputs at reset values.
- With `OTG_RESP_IRQ_EN` undefined, trigger overflow -> ints stay 0 and register 0 reads 0.
